// File: rtl/nexus_status_pkg.sv
// Shared types and helpers for the fault/status controller.
package nexus_status_pkg;

  typedef enum logic [1:0] {
    BLK_IDLE = 2'd0,
    BLK_ON   = 2'd1,
    BLK_OFF  = 2'd2,
    BLK_GAP  = 2'd3
  } blink_state_e;

  // Inter-code gap length, in units of BLINK_CYC.
  localparam int unsigned GAP_MULT = 4;

  // Per-channel debounce status.
  typedef struct packed {
    logic latch_ev;  // counter reaches its limit this cycle
    logic latched;   // sticky fault flag
  } deb_status_t;

  // Lowest set bit index; 0 when nothing is set.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) lowest_idx = 4'(i);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    popcount16 = 5'd0;
    for (int i = 0; i < 16; i++)
      popcount16 = popcount16 + {4'd0, v[i]};
  endfunction

endpackage

// File: rtl/fault_status_ctrl_debounce.sv
// One fault channel: saturating debounce counter plus sticky latch.
module fault_debounce
  import nexus_status_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fault_in,
  input  logic        clear_req,
  output deb_status_t status
);

  localparam int unsigned   CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYC - 1);

  logic [CW-1:0] cnt;
  logic          latched_q;
  logic          latch_ev;

  // Latch fires on the sample that brings the counter to its limit.
  assign latch_ev        = fault_in && (cnt == CNT_ARM);
  assign status.latch_ev = latch_ev;
  assign status.latched  = latched_q;

  // Debounce count and sticky flag; a latch event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      latched_q <= 1'b0;
    end else begin
      if (!fault_in)            cnt <= '0;
      else if (cnt != CNT_MAX)  cnt <= cnt + CW'(1);
      if (latch_ev)                    latched_q <= 1'b1;
      else if (clear_req && !fault_in) latched_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fault_status_ctrl.sv
// Fault latch/trip controller with first-fault capture, event counter,
// heartbeat LED and blink-code error LED.
module fault_status_ctrl
  import nexus_status_pkg::*;
#(
  parameter int unsigned N_FAULTS     = 8,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned HB_CYC       = 25_000_000,
  parameter int unsigned BLINK_CYC    = 12_500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FAULTS-1:0] fault_in,
  input  logic [N_FAULTS-1:0] fault_mask,
  input  logic                clear_req,
  output logic [N_FAULTS-1:0] fault_latched,
  output logic                trip_out,
  output logic [3:0]          first_fault,
  output logic                first_valid,
  output logic [15:0]         fault_count,
  output logic                led_heartbeat,
  output logic                led_error
);

  localparam logic [31:0] HB_LAST  = 32'(HB_CYC - 1);
  localparam logic [31:0] ON_LAST  = 32'(BLINK_CYC - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_MULT * BLINK_CYC - 1);

  deb_status_t [N_FAULTS-1:0] ch_st;
  logic [N_FAULTS-1:0] latch_ev, lat_nxt, new_um;
  logic [16:0]         cnt_sum;

  genvar g;
  generate
    for (g = 0; g < N_FAULTS; g++) begin : g_ch
      fault_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .fault_in  (fault_in[g]),
        .clear_req (clear_req),
        .status    (ch_st[g])
      );
      assign latch_ev[g]      = ch_st[g].latch_ev;
      assign fault_latched[g] = ch_st[g].latched;
    end
  endgenerate

  // Latched vector as it will be after this edge; used to decide whether
  // a clear leaves any unmasked fault standing.
  assign lat_nxt = latch_ev | (fault_latched & ~({N_FAULTS{clear_req}} & ~fault_in));
  assign new_um  = latch_ev & ~fault_mask;
  assign cnt_sum = {1'b0, fault_count} + {12'd0, popcount16(16'(latch_ev))};

  // Trip follows the registered latch state, so it lags a new latch by one cycle.
  always_ff @(posedge clk) begin
    if (rst) trip_out <= 1'b0;
    else     trip_out <= |(fault_latched & ~fault_mask);
  end

  // First-fault capture: load once, drop only when a clear empties the unmasked set.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_valid <= 1'b0;
      first_fault <= 4'd0;
    end else if (!first_valid) begin
      if (|new_um) begin
        first_valid <= 1'b1;
        first_fault <= lowest_idx(16'(new_um));
      end
    end else if (clear_req && !(|(lat_nxt & ~fault_mask))) begin
      first_valid <= 1'b0;
    end
  end

  // Saturating latch-event counter; survives clear_req.
  always_ff @(posedge clk) begin
    if (rst)             fault_count <= 16'd0;
    else if (cnt_sum[16]) fault_count <= 16'hFFFF;
    else                 fault_count <= cnt_sum[15:0];
  end

  logic [31:0] hb_cnt;

  // Free-running heartbeat divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt        <= 32'd0;
      led_heartbeat <= 1'b0;
    end else if (hb_cnt == HB_LAST) begin
      hb_cnt        <= 32'd0;
      led_heartbeat <= ~led_heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end

  blink_state_e state_q, state_d;
  logic [31:0]  tmr;
  logic [4:0]   pulses;

  // Blink FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= BLK_IDLE;
    else     state_q <= state_d;
  end

  // Blink FSM next state; pulse train is cut short when first_valid drops.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BLK_IDLE: if (first_valid) state_d = BLK_ON;
      BLK_ON:   if (tmr == ON_LAST) state_d = BLK_OFF;
      BLK_OFF:  if (tmr == ON_LAST)
                  state_d = (pulses != 5'd0 && first_valid) ? BLK_ON : BLK_GAP;
      BLK_GAP:  if (tmr == GAP_LAST) state_d = BLK_IDLE;
      default:  state_d = BLK_IDLE;
    endcase
  end

  // Phase timer restarts on every state change; pulse count sampled at IDLE->ON.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr    <= 32'd0;
      pulses <= 5'd0;
    end else begin
      if (state_d != state_q || state_q == BLK_IDLE) tmr <= 32'd0;
      else                                            tmr <= tmr + 32'd1;
      if (state_q == BLK_IDLE && state_d == BLK_ON)
        pulses <= {1'b0, first_fault} + 5'd1;
      else if (state_q == BLK_ON && state_d == BLK_OFF)
        pulses <= pulses - 5'd1;
    end
  end

  // Blink FSM output.
  always_comb begin
    led_error = (state_q == BLK_ON);
  end

endmodule

// File: tb/tb_fault_status_ctrl.sv
// Randomized + directed bench for fault_status_ctrl against a behavioural model.
module tb_fault_status_ctrl;

  localparam int N  = 8;
  localparam int D  = 16;
  localparam int HB = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1, clear_req = 1'b0;
  logic [N-1:0] fault_in = '0, fault_mask = '0;
  logic [N-1:0] fault_latched;
  logic         trip_out, first_valid, led_heartbeat, led_error;
  logic [3:0]   first_fault;
  logic [15:0]  fault_count;

  // second instance: single-cycle debounce, used to drive the counter into saturation
  logic         rst2 = 1'b1;
  logic [N-1:0] fault_in2 = '0;
  logic [N-1:0] fault_latched2;
  logic         trip_out2, first_valid2, led_heartbeat2, led_error2;
  logic [3:0]   first_fault2;
  logic [15:0]  fault_count2;

  fault_status_ctrl #(.N_FAULTS(N), .DEBOUNCE_CYC(D), .HB_CYC(HB), .BLINK_CYC(BL)) dut (
    .clk(clk), .rst(rst), .fault_in(fault_in), .fault_mask(fault_mask), .clear_req(clear_req),
    .fault_latched(fault_latched), .trip_out(trip_out), .first_fault(first_fault),
    .first_valid(first_valid), .fault_count(fault_count), .led_heartbeat(led_heartbeat),
    .led_error(led_error));

  fault_status_ctrl #(.N_FAULTS(N), .DEBOUNCE_CYC(1), .HB_CYC(4), .BLINK_CYC(2)) dut2 (
    .clk(clk), .rst(rst2), .fault_in(fault_in2), .fault_mask({N{1'b0}}), .clear_req(1'b0),
    .fault_latched(fault_latched2), .trip_out(trip_out2), .first_fault(first_fault2),
    .first_valid(first_valid2), .fault_count(fault_count2), .led_heartbeat(led_heartbeat2),
    .led_error(led_error2));

  int checks = 0, errors = 0;
  bit chk_en = 0, chk2_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic nclk(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic led; logic pe; } wv_t;
  wv_t          wq[$];            // expected led waveform still to be played
  logic [N-1:0] m_lat;
  bit           m_trip, m_fv, m_hb, m_led, m_idle, last_pe;
  logic [3:0]   m_ff;
  int           m_cnt;
  longint       cyc, hb_n;
  bit           run_on[N];
  longint       rise_t[N];
  int           m2_cnt;
  logic [N-1:0] prev2;

  task automatic push_gap();
    wv_t e;
    e.led = 1'b0; e.pe = 1'b0;
    for (int j = 0; j < 4 * BL; j++) wq.push_back(e);
  endtask

  task automatic fill_code(input int k);
    wv_t e;
    for (int p = 0; p < k; p++) begin
      e.pe = 1'b0;
      e.led = 1'b1;
      for (int j = 0; j < BL; j++) wq.push_back(e);
      e.led = 1'b0;
      for (int j = 0; j < BL; j++) begin
        e.pe = (j == BL - 1) && (p < k - 1);  // decision point for another pulse
        wq.push_back(e);
      end
    end
    push_gap();
  endtask

  task automatic model_step();
    logic [N-1:0] ev, old_lat, new_lat, um;
    bit           old_fv;
    logic [3:0]   old_ff;
    wv_t          e;
    cyc++;
    if (rst) begin
      m_lat = '0; m_trip = 0; m_fv = 0; m_ff = 0; m_cnt = 0; hb_n = 0; m_hb = 0;
      wq.delete(); m_idle = 1; last_pe = 0; m_led = 0;
      for (int i = 0; i < N; i++) run_on[i] = 0;
    end else begin
      ev = '0;
      for (int i = 0; i < N; i++) begin
        if (!fault_in[i]) run_on[i] = 0;
        else begin
          if (!run_on[i]) begin run_on[i] = 1; rise_t[i] = cyc; end
          if (cyc - rise_t[i] + 1 == D) ev[i] = 1'b1;
        end
      end
      old_lat = m_lat; old_fv = m_fv; old_ff = m_ff;
      new_lat = ev | (old_lat & ~(clear_req ? ~fault_in : '0));
      m_trip  = |(old_lat & ~fault_mask);
      um      = ev & ~fault_mask;
      if (!old_fv) begin
        if (um != 0) begin
          m_fv = 1;
          for (int i = N - 1; i >= 0; i--) if (um[i]) m_ff = 4'(i);
        end
      end else if (clear_req && (new_lat & ~fault_mask) == 0) m_fv = 0;
      m_cnt = m_cnt + $countones(ev);
      if (m_cnt > 65535) m_cnt = 65535;
      hb_n++;
      m_hb = ((hb_n / HB) % 2) != 0;
      if (last_pe && !old_fv) begin wq.delete(); push_gap(); end
      if (m_idle && old_fv) fill_code(int'(old_ff) + 1);
      if (wq.size() > 0) begin
        e = wq.pop_front(); m_led = e.led; last_pe = e.pe; m_idle = 0;
      end else begin
        m_led = 0; last_pe = 0; m_idle = 1;
      end
      m_lat = new_lat;
    end
    if (rst2) begin m2_cnt = 0; prev2 = '0; end
    else begin
      m2_cnt = m2_cnt + $countones(fault_in2 & ~prev2);
      if (m2_cnt > 65535) m2_cnt = 65535;
      prev2 = fault_in2;
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end

  // single compare process
  initial forever begin
    @(posedge clk); #2;
    if (chk_en) begin
      chk("latched", 32'(fault_latched), 32'(m_lat));
      chk("trip", 32'(trip_out), 32'(m_trip));
      chk("first_valid", 32'(first_valid), 32'(m_fv));
      if (m_fv) chk("first_fault", 32'(first_fault), 32'(m_ff));
      chk("count", 32'(fault_count), 32'(m_cnt));
      chk("heartbeat", 32'(led_heartbeat), 32'(m_hb));
      chk("led_error", 32'(led_error), 32'(m_led));
    end
    if (chk2_en) chk("count2", 32'(fault_count2), 32'(m2_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic main_seq();
    nclk(3);
    chk_en = 1;
    chk("rst_latched", 32'(fault_latched), 0);
    chk("rst_trip", 32'(trip_out), 0);
    chk("rst_fv", 32'(first_valid), 0);
    chk("rst_count", 32'(fault_count), 0);
    chk("rst_hb", 32'(led_heartbeat), 0);
    chk("rst_led", 32'(led_error), 0);
    rst = 0;
    for (int m = 1; m <= 16; m++) begin
      nclk();
      if (m == 7)  chk("hb_n7", 32'(led_heartbeat), 0);
      if (m == 8)  chk("hb_n8", 32'(led_heartbeat), 1);
      if (m == 15) chk("hb_n15", 32'(led_heartbeat), 1);
      if (m == 16) chk("hb_n16", 32'(led_heartbeat), 0);
    end
    // 15-cycle glitch must not latch, 16 cycles must
    fault_in[3] = 1; nclk(15);
    chk("glitch15", 32'(fault_latched), 0);
    fault_in[3] = 0; nclk();
    fault_in[3] = 1; nclk(16);
    chk("latch16", 32'(fault_latched), 32'h08);
    chk("trip_lag", 32'(trip_out), 0);
    fault_in[3] = 0; nclk();
    chk("trip_after", 32'(trip_out), 1);
    chk("count1", 32'(fault_count), 1);
    clear_req = 1; nclk(); clear_req = 0;
    chk("clr_all", 32'(fault_latched), 0);
    chk("clr_fv", 32'(first_valid), 0);
    nclk(100);
    // channels 5 and 2 latch together
    fault_in = 8'h24; nclk(16);
    chk("dual_lat", 32'(fault_latched), 32'h24);
    chk("dual_fv", 32'(first_valid), 1);
    chk("dual_ff", 32'(first_fault), 2);
    chk("dual_count", 32'(fault_count), 3);
    for (int k = 1; k <= 42; k++) begin
      nclk();
      chk($sformatf("blink_k%0d", k), 32'(led_error),
          (k <= 24) ? 32'(((k - 1) % 8) < 4) : 32'(k == 42));
    end
    // partial clear
    fault_in = 8'h20; clear_req = 1; nclk(); clear_req = 0;
    chk("part_lat", 32'(fault_latched), 32'h20);
    chk("part_fv", 32'(first_valid), 1);
    chk("part_trip", 32'(trip_out), 1);
    fault_in = 0; clear_req = 1; nclk(); clear_req = 0;
    chk("clr2_lat", 32'(fault_latched), 0);
    chk("clr2_fv", 32'(first_valid), 0);
    nclk(100);
    // masked channel 0
    fault_mask = 8'h01; fault_in = 8'h01; nclk(16); fault_in = 0;
    chk("mask_lat", 32'(fault_latched), 32'h01);
    nclk(2);
    chk("mask_trip", 32'(trip_out), 0);
    chk("mask_fv", 32'(first_valid), 0);
    for (int k = 0; k < 40; k++) begin nclk(); chk("mask_led", 32'(led_error), 0); end
    clear_req = 1; nclk(); clear_req = 0; fault_mask = 0;
    // clear_req coincident with latch
    fault_in = 8'h02; nclk(15); clear_req = 1; nclk(); clear_req = 0;
    chk("clr_vs_latch", 32'(fault_latched), 32'h02);
    fault_in = 0;
    // reset during ON
    for (int w = 0; w < 40 && led_error !== 1'b1; w++) nclk();
    chk("led_on_seen", 32'(led_error), 1);
    rst = 1; nclk();
    chk("mid_rst", {fault_latched, trip_out, first_fault, first_valid, led_heartbeat, led_error}, 0);
    chk("mid_rst_cnt", 32'(fault_count), 0);
    rst = 0;
    // random
    for (int t = 0; t < 3000; t++) begin
      nclk();
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 19) == 0) fault_in[i] = ~fault_in[i];
      if ($urandom_range(0, 63) == 0) fault_mask = N'($urandom());
      clear_req = ($urandom_range(0, 29) == 0);
    end
    rst = 0; clear_req = 0; nclk(2);
  endtask

  task automatic sat_seq();
    nclk(2);
    chk2_en = 1; rst2 = 0;
    repeat (8191) begin fault_in2 = '1; nclk(); fault_in2 = '0; nclk(); end
    fault_in2 = 8'h3F; nclk(); fault_in2 = '0;
    chk("sat_fffe", 32'(fault_count2), 32'hFFFE);
    nclk();
    fault_in2 = 8'h03; nclk(); fault_in2 = '0;
    chk("sat_ffff", 32'(fault_count2), 32'hFFFF);
    nclk();
    fault_in2 = '1; nclk(); fault_in2 = '0;
    chk("sat_hold", 32'(fault_count2), 32'hFFFF);
    chk("sat_lat", 32'(fault_latched2), 32'hFF);
    chk("sat_trip", 32'(trip_out2), 1);
    chk("sat_fv", {first_valid2, first_fault2}, 32'h10);
    nclk();
  endtask

  initial begin
    fork
      main_seq();
      sat_seq();
    join
    chk_en = 0; chk2_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_status_ctrl.md
FAULT_STATUS_CTRL -- requirements
Module: fault_status_ctrl

Interface
REQ-001 SHALL have parameter N_FAULTS, default 8, number of fault channels (range 1..16).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 16, consecutive high samples required to latch a fault (range 1..65535).
REQ-003 SHALL have parameter HB_CYC, default 25_000_000, heartbeat half-period in clk cycles.
REQ-004 SHALL have parameter BLINK_CYC, default 12_500_000, blink-code on-time and off-time in clk cycles; inter-code gap is 4*BLINK_CYC.
REQ-005 SHALL have port clk, input, 1, system clock; one clock domain.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port fault_in, input, N_FAULTS, raw fault flags, already synchronous to clk.
REQ-008 SHALL have port fault_mask, input, N_FAULTS, 1 = channel excluded from trip, first-fault and blink code.
REQ-009 SHALL have port clear_req, input, 1, single-cycle request to clear latched faults.
REQ-010 SHALL have port fault_latched, output, N_FAULTS, latched fault status, masked and unmasked.
REQ-011 SHALL have port trip_out, output, 1, registered OR of unmasked latched faults.
REQ-012 SHALL have port first_fault, output, 4, index of first unmasked fault latched since the last clear.
REQ-013 SHALL have port first_valid, output, 1, first_fault is valid.
REQ-014 SHALL have port fault_count, output, 16, number of latch events, saturating.
REQ-015 SHALL have port led_heartbeat, output, 1, heartbeat square wave.
REQ-016 SHALL have port led_error, output, 1, blink-code output.

Function
REQ-017 SHALL keep one debounce counter per channel: increment while fault_in[i]=1 and saturate at DEBOUNCE_CYC; reset to 0 on any cycle with fault_in[i]=0.
REQ-018 SHALL set fault_latched[i] on the edge where the counter reaches DEBOUNCE_CYC, i.e. DEBOUNCE_CYC cycles after fault_in[i] rises; a glitch of DEBOUNCE_CYC-1 cycles SHALL NOT latch.
REQ-019 SHALL leave fault_latched[i] set once latched, independent of fault_in, until cleared per REQ-020.
REQ-020 SHALL, on clear_req, clear only those bits whose fault_in[i]=0 in that cycle; channels still asserted stay latched.
REQ-021 SHALL let a latch event take priority over clear_req when both target the same channel in the same cycle.
REQ-022 SHALL assert trip_out exactly one cycle after an unmasked fault_latched bit sets; a mask change SHALL take effect on trip_out one cycle later.
REQ-023 SHALL, when first_valid=0, load first_fault with the lowest index among unmasked channels latching in the current cycle and set first_valid; once set it SHALL hold until a clear_req leaves no unmasked latched bits.
REQ-024 SHALL add the number of channels latching in a cycle to fault_count (popcount, 0..N_FAULTS), saturating at 16'hFFFF; clear_req SHALL NOT reset fault_count.
REQ-025 SHALL toggle led_heartbeat every HB_CYC cycles from a free-running counter, wrapping at HB_CYC-1.
REQ-026 SHALL drive led_error from a blink FSM with states IDLE, ON, OFF, GAP.
REQ-027 SHALL make IDLE->ON when first_valid=1, loading a pulse counter with first_fault+1; ON lasts BLINK_CYC with led_error=1.
REQ-028 SHALL make ON->OFF after BLINK_CYC cycles, then decrement the pulse counter; OFF lasts BLINK_CYC with led_error=0.
REQ-029 SHALL make OFF->ON if pulses remain, else OFF->GAP; GAP lasts 4*BLINK_CYC with led_error=0, then returns to IDLE, which repeats the code while first_valid=1.
REQ-030 SHALL let first_valid falling mid-sequence finish the current pulse and go to GAP; a first_fault change SHALL apply only at the next IDLE->ON.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, set all debounce counters, fault_latched, trip_out, first_fault, first_valid, fault_count, led_heartbeat and led_error to 0, the heartbeat counter to 0, and the blink FSM to IDLE; rst SHALL override all other inputs, including mid-blink and mid-debounce.

Structure
REQ-032 SHALL place the FSM state encoding and the GAP multiplier constant (4) in the shared package nexus_status_pkg.
REQ-033 SHALL implement the per-channel debounce/latch as sub-module fault_debounce, instantiated N_FAULTS times via generate.

Verification
REQ-034 SHALL cover: DEBOUNCE_CYC=16, fault_in[3] high 15 cycles -> no latch; high 16 cycles -> fault_latched[3]=1 at cycle 16, trip_out=1 at cycle 17, fault_count=1.
REQ-035 SHALL cover: fault_in[5] and fault_in[2] latching in the same cycle -> first_fault=2, fault_count=2; BLINK_CYC=4 -> three 4-cycle pulses on led_error, then 16-cycle gap.
REQ-036 SHALL cover: clear_req with fault_in[2]=0 and fault_in[5]=1 -> only bit 2 clears, first_valid stays 1, trip_out stays 1.
REQ-037 SHALL cover: fault_mask[0]=1 and channel 0 latches -> fault_latched[0]=1, trip_out=0, first_valid=0, led_error stays 0.
REQ-038 SHALL cover: fault_count preloaded to 16'hFFFE and two channels latch -> 16'hFFFF; HB_CYC=8 -> led_heartbeat period 16 cycles.
REQ-039 SHALL cover: rst asserted during the ON state -> next cycle all outputs 0 and FSM IDLE; clear_req in the latch cycle -> bit stays set.
